writeback_stage: RTL

//  M/W pipeline register and write-back control of the pipelined CPU. Sits directly upstream of
//  the register file: captures the memory-stage result and drives its write port (valE/valM/destE/destM).

---
 rtl/writeback_stage.sv | 95 +++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// M/W pipeline register and register-file write-back control.
// Holds the memory-stage result, gates the write port, freezes on a fault and counts retirements.
module writeback_stage #(
    parameter int unsigned         DATA_WID = 32,
    parameter int unsigned         ADDR_WID = 4,
    parameter logic [ADDR_WID-1:0] RNONE    = '1,
    parameter int unsigned         CNT_WID  = 32
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                m_valid,
    input  logic [2:0]          m_stat,
    input  logic [DATA_WID-1:0] m_valE,
    input  logic [DATA_WID-1:0] m_valM,
    input  logic [ADDR_WID-1:0] m_destE,
    input  logic [ADDR_WID-1:0] m_destM,
    input  logic                W_stall,
    input  logic                W_bubble,
    output logic [DATA_WID-1:0] valE,
    output logic [DATA_WID-1:0] valM,
    output logic [ADDR_WID-1:0] destE,
    output logic [ADDR_WID-1:0] destM,
    output logic                W_valid,
    output logic [2:0]          W_stat,
    output logic                halted,
    output logic [CNT_WID-1:0]  retired
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    logic [DATA_WID-1:0] W_valE;
    logic [DATA_WID-1:0] W_valM;
    logic [ADDR_WID-1:0] W_destE;
    logic [ADDR_WID-1:0] W_destM;
    logic                freeze;
    logic                write_ok;
    logic                commit;

    always_comb begin
        halted   = W_valid && (W_stat != STAT_AOK);
        freeze   = W_stall || halted;
        write_ok = W_valid && (W_stat == STAT_AOK);
        commit   = write_ok && !freeze;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            W_valid <= 1'b0;
            W_stat  <= STAT_AOK;
            W_valE  <= '0;
            W_valM  <= '0;
            W_destE <= RNONE;
            W_destM <= RNONE;
            retired <= '0;
        end else begin
            if (!freeze) begin
                if (W_bubble) begin
                    W_valid <= 1'b0;
                    W_stat  <= STAT_AOK;
                    W_valE  <= '0;
                    W_valM  <= '0;
                    W_destE <= RNONE;
                    W_destM <= RNONE;
                end else begin
                    W_valid <= m_valid;
                    W_stat  <= m_stat;
                    W_valE  <= m_valE;
                    W_valM  <= m_valM;
                    W_destE <= m_valid ? m_destE : RNONE;
                    W_destM <= m_valid ? m_destM : RNONE;
                end
            end
            if (commit) begin
                retired <= retired + CNT_WID'(1);
            end
        end
    end

    // On a same-index conflict only the memory result is written.
    always_comb begin
        valE  = W_valE;
        valM  = W_valM;
        destM = write_ok ? W_destM : RNONE;
        destE = RNONE;
        if (write_ok && !((W_destE == W_destM) && (W_destE != RNONE))) begin
            destE = W_destE;
        end
    end

endmodule
